// File: rtl/logic_op_pipe_if.sv
// Handshake bundle between operand source, logic_op_pipe and result consumer.
interface logic_op_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] out_cnt;

  // Source/consumer side
  modport master (
    output in_valid, a, b, op, acc, last, out_ready,
    input  in_ready, out_valid, out, out_cnt
  );

  // Logic unit side
  modport slave (
    input  in_valid, a, b, op, acc, last, out_ready,
    output in_ready, out_valid, out, out_cnt
  );
endinterface

// File: rtl/logic_op_pipe.sv
// Bitwise two-operand logic unit with registered output, valid/ready on both
// sides and optional multi-beat burst reduction with a saturating beat count.
//
// state | meaning
// IDLE  | no burst open; single beats emit directly
// ACCUM | burst open; beats fold into acc_q until a beat with last=1
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  logic_op_pipe_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] folded;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] lop(input logic [1:0]       f,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    case (f)
      2'b00:   lop = x & y;
      2'b01:   lop = x | y;
      2'b10:   lop = x ^ y;
      default: lop = x;
    endcase
  endfunction

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  // Inside a burst the opcode captured on the opening beat governs every beat.
  assign op_eff        = (state_q == ACCUM) ? op_q : bus.op;
  assign p             = lop(op_eff[1:0], bus.a, bus.b);
  // PASS folds to the newest beat's a, which is exactly p.
  assign folded        = (op_q[1:0] == 2'b11) ? p : lop(op_q[1:0], acc_q, p);
  assign cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  assign bus.out       = out_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_valid = out_valid_q;

  // Next-state: burst FSM, accumulator update and output register load.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!bus.acc || bus.last) begin
            out_d       = bus.op[2] ? ~p : p;
            out_cnt_d   = CNT_W'(1);
            out_valid_d = 1'b1;
          end else begin
            acc_d   = p;
            op_d    = bus.op;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.last) begin
            out_d       = op_q[2] ? ~folded : folded;
            out_cnt_d   = cnt_inc;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            acc_d = folded;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: single-beat vector table plus hand-written
// burst, backpressure, reset and saturation sequences.
module tb_logic_op_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic_op_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();

  logic_op_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic       last;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vt[11];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] sb[$];

  // Record every result the consumer actually takes.
  always @(posedge clk)
    if (!rst && bus.out_valid && bus.out_ready) sb.push_back(bus.out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic acc, input logic last);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc      = acc;
    bus.last     = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{3'b001, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{3'b001, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF};
    vt[2]  = '{3'b001, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF};
    vt[3]  = '{3'b001, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF};
    vt[4]  = '{3'b000, 8'h0F, 8'h3C, 1'b0, 1'b0, 8'h0C};
    vt[5]  = '{3'b010, 8'h0F, 8'h3C, 1'b0, 1'b0, 8'h33};
    vt[6]  = '{3'b011, 8'h5A, 8'hFF, 1'b0, 1'b0, 8'h5A};
    vt[7]  = '{3'b100, 8'h0F, 8'h3C, 1'b0, 1'b0, 8'hF3};
    vt[8]  = '{3'b101, 8'h0F, 8'h30, 1'b0, 1'b0, 8'hC0};
    vt[9]  = '{3'b111, 8'h5A, 8'h00, 1'b0, 1'b1, 8'hA5};
    vt[10] = '{3'b000, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.acc       = 1'b0;
    bus.last      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'h00);
    check("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Single beats back-to-back: one result per cycle, one cycle after accept.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].acc, vt[i].last);
      step();
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_out", i),   32'(bus.out),       32'(vt[i].exp_out));
      check($sformatf("vec%0d_cnt", i),   32'(bus.out_cnt),   32'd1);
    end

    // NOR burst; later beats carry a different op/acc that must be ignored.
    drive(3'b101, 8'h01, 8'h00, 1'b1, 1'b0);
    step();
    check("nor_b1_valid", 32'(bus.out_valid), 32'd0);
    drive(3'b000, 8'h02, 8'h00, 1'b0, 1'b0);
    step();
    check("nor_b2_valid", 32'(bus.out_valid), 32'd0);
    drive(3'b010, 8'h80, 8'h00, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("nor_valid", 32'(bus.out_valid), 32'd1);
    check("nor_out",   32'(bus.out),       32'h7C);
    check("nor_cnt",   32'(bus.out_cnt),   32'd3);
    step();
    check("nor_drop_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: result held, input stalled, then released.
    sb.delete();
    bus.out_ready = 1'b0;
    drive(3'b000, 8'hFF, 8'h0F, 1'b0, 1'b0);
    step();
    drive(3'b001, 8'h00, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d_out", i),      32'(bus.out),       32'h0F);
      check($sformatf("bp%0d_valid", i),    32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("bp_rel_out", 32'(bus.out), 32'h11);
    check("bp_rel_valid", 32'(bus.out_valid), 32'd1);
    step();
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_sb_size", 32'(sb.size()), 32'd2);
    if (sb.size() == 2) begin
      check("bp_sb0", 32'(sb[0]), 32'h0F);
      check("bp_sb1", 32'(sb[1]), 32'h11);
    end

    // Reset in the middle of a burst discards the partial result.
    drive(3'b001, 8'hF0, 8'h00, 1'b1, 1'b0);
    step();
    drive(3'b001, 8'h0F, 8'h00, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_out",   32'(bus.out),       32'h00);
    check("mrst_cnt",   32'(bus.out_cnt),   32'd0);
    drive(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("mrst_and_valid", 32'(bus.out_valid), 32'd1);
    check("mrst_and_out",   32'(bus.out),       32'h30);
    check("mrst_and_cnt",   32'(bus.out_cnt),   32'd1);
    step();

    // 300-beat XOR burst: even number of ones folds to 0, count saturates.
    for (int i = 0; i < 300; i++) begin
      drive(3'b010, 8'h01, 8'h00, 1'b1, (i == 299) ? 1'b1 : 1'b0);
      step();
      if (i == 298) check("xor_mid_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("xor_valid", 32'(bus.out_valid), 32'd1);
    check("xor_out",   32'(bus.out),       32'h00);
    check("xor_cnt",   32'(bus.out_cnt),   32'hFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
